pm_loader: RTL and testbench
============================

# pm_loader

Program-memory loader for the MPU341 core: the write-side counterpart of the program sequencer/ROM read path. It accepts a stream of 4-bit nibbles from a host over a valid/ready handshake and packs them MS-nibble-first into 8-bit instruction words. It writes the words sequentially into the 256×8 program memory write port and holds the MPU in reset for the whole load. On completion it releases the core so execution starts at address 0x00 with the new program.

## Interface
Parameters:
- ADDR_W, 8, program memory address width (256 words)
- DATA_W, 8, instruction word width
- NIB_W, 4, host nibble width
- RELEASE_CYCLES, 2, cycles `mpu_reset` stays high after the final write (covers the MPU's reset synchroniser flop)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- start  in  1  single-cycle request to begin a load; ignored unless in IDLE
- nib_data  in  NIB_W  host nibble
- nib_valid  in  1  host nibble valid
- nib_last  in  1  qualifies nib_data as the final nibble; legal only on an LS nibble
- nib_ready  out  1  loader accepts a nibble this cycle
- pm_wr_en  out  1  program memory write strobe
- pm_wr_addr  out  ADDR_W  write address
- pm_wr_data  out  DATA_W  write data
- mpu_reset  out  1  active-high reset to the MPU top
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when `mpu_reset` is released after a good load
- err  out  1  sticky protocol error flag
- word_count  out  ADDR_W+1  number of words written in the current or last load

## Operation
- States: IDLE, GET_HI, GET_LO, WRITE, RELEASE, ERROR.
- A transfer occurs on a rising edge where `nib_valid && nib_ready`. `nib_ready` is 1 only in GET_HI and GET_LO.
- IDLE:
  - `mpu_reset`=0.
  - `start` → GET_HI; address cleared to 0, `word_count`=0, `err`=0.
- GET_HI:
  - On transfer, latch the nibble as word[7:4].
  - `nib_last`=1 on this transfer → ERROR, with no write.
  - Otherwise → GET_LO.
- GET_LO:
  - On transfer, latch the nibble as word[3:0], remember `nib_last`, → WRITE.
- WRITE (one cycle):
  - `pm_wr_en`=1 with `pm_wr_addr`=current address and `pm_wr_data`=assembled word.
  - `word_count`+1; address+1 (mod 256).
  - If the latched last=1 → RELEASE.
  - Else, if this was the write to 0xFF → ERROR (overflow).
  - Else → GET_HI.
- RELEASE:
  - Count RELEASE_CYCLES cycles with `mpu_reset`=1.
  - Then → IDLE: `mpu_reset` drops and `done` pulses in the same cycle.
- ERROR:
  - `err`=1, `mpu_reset`=1, `nib_ready`=0.
  - Leaves only on `start` (→ GET_HI, `err` cleared) or reset.
- `mpu_reset`=1 and `busy`=1 in GET_HI, GET_LO, WRITE, RELEASE.
- `busy`=0 in ERROR; `busy`=0 and `mpu_reset`=0 in IDLE.
- `start` outside IDLE/ERROR is ignored.
- Stalls: `nib_valid` low in GET_HI or GET_LO holds the state indefinitely; no timeout.
- Reset asserted mid-load:
  - Partial word is discarded; no write is issued.
  - All outputs take their reset values.
  - The next load starts at 0x00.

## Timing
- Reset values while `reset`=0:
  - `mpu_reset`=1; `nib_ready`, `pm_wr_en`, `busy`, `done`, `err`=0.
  - `pm_wr_addr`=0, `pm_wr_data`=0, `word_count`=0.
- First cycle after reset release: IDLE, so `mpu_reset`=0.
- All outputs are registered.
- `start` sampled at edge N → `nib_ready`=1 and `mpu_reset`=1 from cycle N+1.
- LS nibble accepted at edge N → `pm_wr_en` high during cycle N+1 only.
- Program memory samples the write on the falling edge inside that cycle. Address and data are stable for the whole cycle.
- Throughput: one word per 3 cycles at full host rate (HI, LO, WRITE).
- Last write in cycle W → `mpu_reset` high through cycle W+RELEASE_CYCLES and low from W+RELEASE_CYCLES+1; `done` pulses in W+RELEASE_CYCLES+1.
- `word_count` reaches 256 on a full load, hence the ADDR_W+1 width.

## Structure
- Shared package `pm_loader_pkg`:
  - state enum
  - ADDR_W/DATA_W/NIB_W defaults
  - RELEASE_CYCLES
  - `PM_DEPTH`=256
- Single flat module; no sub-module warranted.
- Top-level integration (outside this block):
  - `mpu_reset` ORs into the MPU `reset` input.
  - Write port connects to a dual-port program memory.

## Test plan
- Reset held low 3 cycles → `mpu_reset`=1, all other outputs 0. Cycle after release → `mpu_reset`=0, `busy`=0.
- `start`, then nibbles A,5,3,C at full rate with `nib_last` on C → writes (0x00,0xA5) and (0x01,0x3C). `mpu_reset` falls 3 cycles after the second write, `done` pulses once, `word_count`=2, `err`=0.
- Same stream with `nib_valid` gaps of 0–4 random cycles, and valid held high during WRITE → identical writes, no nibble lost or duplicated, `nib_ready`=0 in every WRITE cycle.
- `start`, then nibble 7 with `nib_last`=1 on the MS nibble → no `pm_wr_en`, `err`=1, `mpu_reset` stays 1. A following `start` clears `err` and loads at 0x00.
- 512 nibbles without `nib_last` → 256 writes at 0x00–0xFF, `word_count`=256, then ERROR with `nib_ready`=0. Further nibbles are not accepted.
- Reset asserted after 3 nibbles (one word written) → no further writes, `mpu_reset`=1 during reset. A new load writes its first word at 0x00.

Source files
------------

// File: rtl/pm_loader_pkg.sv
// Shared definitions for the MPU341 program-memory loader.
// Default widths, release timing and the loader state encoding.
package pm_loader_pkg;

  localparam int DEF_ADDR_W         = 8;
  localparam int DEF_DATA_W         = 8;
  localparam int DEF_NIB_W          = 4;
  localparam int DEF_RELEASE_CYCLES = 2;
  localparam int PM_DEPTH           = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_HI,
    ST_GET_LO,
    ST_WRITE,
    ST_RELEASE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/pm_loader_if.sv
// Host nibble stream plus program-memory write port of the loader.
// master = host/memory side, slave = loader side.
interface pm_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int NIB_W  = 4
) ();

  logic [NIB_W-1:0]  nib_data;
  logic              nib_valid;
  logic              nib_last;
  logic              nib_ready;
  logic              pm_wr_en;
  logic [ADDR_W-1:0] pm_wr_addr;
  logic [DATA_W-1:0] pm_wr_data;

  modport master (
    output nib_data, nib_valid, nib_last,
    input  nib_ready, pm_wr_en, pm_wr_addr, pm_wr_data
  );

  modport slave (
    input  nib_data, nib_valid, nib_last,
    output nib_ready, pm_wr_en, pm_wr_addr, pm_wr_data
  );

endinterface

// File: rtl/pm_loader.sv
// Packs host nibbles MS-first into instruction words, writes them from 0x00
// upward and holds the MPU in reset until the load completes.
module pm_loader
  import pm_loader_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int NIB_W          = DEF_NIB_W,
  parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  pm_loader_if.slave      bus,
  output logic            mpu_reset,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [ADDR_W:0] word_count
);

  localparam int               CNT_W    = ADDR_W + 1;
  localparam int               REL_W    = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [NIB_W-1:0]  hi_nib;
  logic              last_q;
  logic [REL_W-1:0]  rel_cnt;
  logic              xfer;

  assign xfer = bus.nib_valid & bus.nib_ready;

  // NOTE: every output is a flop written with <= in this one block, so the
  // outputs change only at the clock edge and never glitch with the inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= ST_IDLE;
      addr           <= '0;
      hi_nib         <= '0;
      last_q         <= 1'b0;
      rel_cnt        <= '0;
      bus.nib_ready  <= 1'b0;
      bus.pm_wr_en   <= 1'b0;
      bus.pm_wr_addr <= '0;
      bus.pm_wr_data <= '0;
      mpu_reset      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      word_count     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            state         <= ST_GET_HI;
            addr          <= '0;
            word_count    <= '0;
            err           <= 1'b0;
            busy          <= 1'b1;
            mpu_reset     <= 1'b1;
            bus.nib_ready <= 1'b1;
          end else if (state == ST_IDLE) begin
            // Leaving power-on reset: the core runs whatever is resident.
            mpu_reset <= 1'b0;
          end
        end

        ST_GET_HI: begin
          if (xfer) begin
            hi_nib <= bus.nib_data;
            if (bus.nib_last) begin
              // A stream may only end on an LS nibble; nothing is written.
              state         <= ST_ERROR;
              err           <= 1'b1;
              busy          <= 1'b0;
              bus.nib_ready <= 1'b0;
            end else begin
              state <= ST_GET_LO;
            end
          end
        end

        ST_GET_LO: begin
          if (xfer) begin
            last_q         <= bus.nib_last;
            bus.pm_wr_en   <= 1'b1;
            bus.pm_wr_addr <= addr;
            bus.pm_wr_data <= DATA_W'({hi_nib, bus.nib_data});
            bus.nib_ready  <= 1'b0;
            state          <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          bus.pm_wr_en <= 1'b0;
          word_count   <= word_count + CNT_W'(1);
          addr         <= addr + ADDR_W'(1);
          if (last_q) begin
            state   <= ST_RELEASE;
            rel_cnt <= '0;
          end else if (addr == '1) begin
            // Memory is full and the host still has not marked the end.
            state <= ST_ERROR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state         <= ST_GET_HI;
            bus.nib_ready <= 1'b1;
          end
        end

        ST_RELEASE: begin
          if (rel_cnt == REL_LAST) begin
            state     <= ST_IDLE;
            mpu_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            rel_cnt <= rel_cnt + REL_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pm_loader.sv
// Self-checking bench for pm_loader: reset values, table-driven loads,
// timing corners and randomized streams checked against a word-level model.
module tb_pm_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       mpu_reset, busy, done, err;
  logic [8:0] word_count;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  logic [15:0] wr_q[$];
  logic [15:0] exp_q[$];
  bit          exp_err;

  pm_loader_if #(.ADDR_W(8), .DATA_W(8), .NIB_W(4)) bus ();

  pm_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .mpu_reset  (mpu_reset),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write-port monitor: every strobe is recorded; the loader must never
  // offer to accept a nibble while it is writing.
  always @(negedge clk) begin
    if (bus.pm_wr_en === 1'b1) begin
      wr_q.push_back({bus.pm_wr_addr, bus.pm_wr_data});
      check("ready_in_write", 32'(bus.nib_ready), 32'd0);
    end
    if (done === 1'b1) done_cnt++;
  end

  // Word-level reference: pair nibbles MS-first, addresses count from 0,
  // a last flag on an MS nibble or running past 256 words is an error.
  task automatic model_run(input logic [3:0] nibs[$], input bit lasts[$]);
    exp_q.delete();
    exp_err = 1'b0;
    for (int k = 0; 2 * k < nibs.size(); k++) begin
      if (lasts[2*k]) begin exp_err = 1'b1; break; end
      if (2 * k + 1 >= nibs.size()) break;
      exp_q.push_back({8'(k), nibs[2*k], nibs[2*k+1]});
      if (lasts[2*k+1]) break;
      if (k == 255) begin exp_err = 1'b1; break; end
    end
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_ready", 32'(bus.nib_ready), 32'd1);
    check("start_mpu_reset", 32'(mpu_reset), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_err_clear", 32'(err), 32'd0);
  endtask

  // Presents one nibble after `gap` idle cycles and returns right after the
  // edge on which it was accepted.
  task automatic send(input logic [3:0] d, input bit l, input int gap);
    bit rdy;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk); bus.nib_valid = 1'b0;
    end
    @(negedge clk);
    bus.nib_valid = 1'b1;
    bus.nib_data  = d;
    bus.nib_last  = l;
    for (int t = 0; t < 200; t++) begin
      rdy = bus.nib_ready;
      @(posedge clk);
      if (rdy) return;
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL xfer_timeout: nibble 0x%0h not accepted in 200 cycles", d);
  endtask

  task automatic end_stream();
    @(negedge clk);
    bus.nib_valid = 1'b0;
    bus.nib_last  = 1'b0;
  endtask

  task automatic run_load(input logic [3:0] nibs[$], input bit lasts[$], input int gap_max);
    wr_q.delete();
    done_cnt = 0;
    do_start();
    foreach (nibs[i]) send(nibs[i], lasts[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    end_stream();
    repeat (8) @(negedge clk);
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_n_writes"}, 32'(wr_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < wr_q.size()) check($sformatf("%s_wr%0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
    end
    check({tag, "_word_count"}, 32'(word_count), 32'(exp_q.size()));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  typedef struct {
    logic [3:0] n[4];
    int         gap_max;
    logic [7:0] w0;
    logic [7:0] w1;
  } vec_t;

  initial begin
    vec_t       vecs[4];
    logic [3:0] nibs[$];
    bit         lasts[$];
    int         nw;

    bus.nib_valid = 1'b0;
    bus.nib_data  = '0;
    bus.nib_last  = 1'b0;

    vecs[0] = '{n: '{4'hA, 4'h5, 4'h3, 4'hC}, gap_max: 0, w0: 8'hA5, w1: 8'h3C};
    vecs[1] = '{n: '{4'hA, 4'h5, 4'h3, 4'hC}, gap_max: 4, w0: 8'hA5, w1: 8'h3C};
    vecs[2] = '{n: '{4'h0, 4'h0, 4'hF, 4'hF}, gap_max: 2, w0: 8'h00, w1: 8'hFF};
    vecs[3] = '{n: '{4'h1, 4'h2, 4'h3, 4'h4}, gap_max: 0, w0: 8'h12, w1: 8'h34};

    // Reset values, then IDLE with the core released.
    repeat (3) @(negedge clk);
    check("rst_mpu_reset", 32'(mpu_reset), 32'd1);
    check("rst_ready", 32'(bus.nib_ready), 32'd0);
    check("rst_wr_en", 32'(bus.pm_wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr_data", 32'({bus.pm_wr_addr, bus.pm_wr_data}), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_mpu_reset", 32'(mpu_reset), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Hand sequence: release timing after the final write.
    wr_q.delete();
    done_cnt = 0;
    do_start();
    send(4'hA, 1'b0, 0);
    send(4'h5, 1'b0, 0);
    send(4'h3, 1'b0, 0);
    send(4'hC, 1'b1, 0);
    @(negedge clk);
    bus.nib_valid = 1'b0;
    bus.nib_last  = 1'b0;
    check("last_wr_en", 32'(bus.pm_wr_en), 32'd1);
    check("last_wr_addr", 32'(bus.pm_wr_addr), 32'h01);
    check("last_wr_data", 32'(bus.pm_wr_data), 32'h3C);
    @(negedge clk);
    check("rel_w1_mpu_reset", 32'(mpu_reset), 32'd1);
    @(negedge clk);
    check("rel_w2_mpu_reset", 32'(mpu_reset), 32'd1);
    check("rel_w2_done", 32'(done), 32'd0);
    @(negedge clk);
    check("rel_w3_mpu_reset", 32'(mpu_reset), 32'd0);
    check("rel_w3_done", 32'(done), 32'd1);
    check("rel_w3_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("rel_w4_done", 32'(done), 32'd0);
    check("rel_done_count", 32'(done_cnt), 32'd1);
    check("rel_first_write", 32'(wr_q.size() > 0 ? wr_q[0] : 16'hDEAD), 32'h00A5);

    // Table-driven two-word loads.
    foreach (vecs[v]) begin
      nibs  = '{vecs[v].n[0], vecs[v].n[1], vecs[v].n[2], vecs[v].n[3]};
      lasts = '{1'b0, 1'b0, 1'b0, 1'b1};
      run_load(nibs, lasts, vecs[v].gap_max);
      check($sformatf("vec%0d_n_writes", v), 32'(wr_q.size()), 32'd2);
      if (wr_q.size() == 2) begin
        check($sformatf("vec%0d_wr0", v), 32'(wr_q[0]), 32'({8'h00, vecs[v].w0}));
        check($sformatf("vec%0d_wr1", v), 32'(wr_q[1]), 32'({8'h01, vecs[v].w1}));
      end
      check($sformatf("vec%0d_word_count", v), 32'(word_count), 32'd2);
      check($sformatf("vec%0d_done_pulses", v), 32'(done_cnt), 32'd1);
      check($sformatf("vec%0d_err", v), 32'(err), 32'd0);
      check($sformatf("vec%0d_mpu_reset", v), 32'(mpu_reset), 32'd0);
    end

    // Last flag on an MS nibble.
    wr_q.delete();
    do_start();
    send(4'h7, 1'b1, 0);
    end_stream();
    repeat (3) @(negedge clk);
    check("mslast_writes", 32'(wr_q.size()), 32'd0);
    check("mslast_err", 32'(err), 32'd1);
    check("mslast_mpu_reset", 32'(mpu_reset), 32'd1);
    check("mslast_busy", 32'(busy), 32'd0);
    check("mslast_ready", 32'(bus.nib_ready), 32'd0);
    nibs  = '{4'hA, 4'h5, 4'h3, 4'hC};
    lasts = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_load(nibs, lasts, 0);
    model_run(nibs, lasts);
    compare_model("after_err");

    // Randomized loads with host gaps.
    for (int r = 0; r < 12; r++) begin
      nw = int'($urandom_range(1, 8));
      nibs.delete();
      lasts.delete();
      for (int i = 0; i < 2 * nw; i++) begin
        nibs.push_back(4'($urandom));
        lasts.push_back(i == 2 * nw - 1);
      end
      run_load(nibs, lasts, 4);
      model_run(nibs, lasts);
      compare_model($sformatf("rand%0d", r));
      check($sformatf("rand%0d_done", r), 32'(done_cnt), 32'd1);
    end

    // Overflow: 512 nibbles, never marked last.
    nibs.delete();
    lasts.delete();
    for (int i = 0; i < 512; i++) begin
      nibs.push_back(4'($urandom));
      lasts.push_back(1'b0);
    end
    run_load(nibs, lasts, 0);
    model_run(nibs, lasts);
    compare_model("ovf");
    check("ovf_ready", 32'(bus.nib_ready), 32'd0);
    check("ovf_mpu_reset", 32'(mpu_reset), 32'd1);
    @(negedge clk);
    bus.nib_valid = 1'b1;
    bus.nib_data  = 4'h9;
    repeat (10) @(negedge clk);
    bus.nib_valid = 1'b0;
    check("ovf_no_more_writes", 32'(wr_q.size()), 32'd256);
    check("ovf_ready_held", 32'(bus.nib_ready), 32'd0);

    // Reset in the middle of a load.
    wr_q.delete();
    do_start();
    send(4'hB, 1'b0, 0);
    send(4'hE, 1'b0, 0);
    send(4'hD, 1'b0, 0);
    @(negedge clk);
    bus.nib_valid = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_mpu_reset", 32'(mpu_reset), 32'd1);
    check("midrst_wr_en", 32'(bus.pm_wr_en), 32'd0);
    check("midrst_word_count", 32'(word_count), 32'd0);
    check("midrst_writes", 32'(wr_q.size()), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    nibs  = '{4'h6, 4'h1, 4'h0, 4'h8};
    lasts = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_load(nibs, lasts, 1);
    model_run(nibs, lasts);
    compare_model("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
